// File: rtl/l1_pkg.sv
// Shared types and derived widths for the L1 refill controller.
package l1_pkg;

    localparam int unsigned L1_WAY_NUM     = 4;
    localparam int unsigned CORE_IDX_WIDTH = 6;
    localparam int unsigned L1_TAG_W       = 22;
    localparam int unsigned L1_BEATS       = 4;
    localparam int unsigned L1_DATA_W      = 32;
    localparam int unsigned L1_BEAT_W      = $clog2(L1_BEATS);
    localparam int unsigned L1_ADDR_W      = L1_TAG_W + CORE_IDX_WIDTH + L1_BEAT_W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StWbRd,
        StWbReq,
        StRfReq,
        StRfWait,
        StUpd,
        StDone
    } state_e;

    // Byte address of one beat: {tag, idx, beat, 2'b00}. Widths are passed in so any
    // parameterisation can share it; the caller truncates to its own address width.
    function automatic logic [63:0] line_addr(input logic [63:0]   tag,
                                              input logic [63:0]   idx,
                                              input logic [63:0]   beat,
                                              input int unsigned   idx_w,
                                              input int unsigned   beat_w);
        return (tag << (idx_w + beat_w + 2)) | (idx << (beat_w + 2)) | (beat << 2);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// Miss, memory, data-array and tag-array signals of the refill controller.
interface l1_refill_ctrl_if #(
    parameter int unsigned WAY_NUM = l1_pkg::L1_WAY_NUM,
    parameter int unsigned IDX_W   = l1_pkg::CORE_IDX_WIDTH,
    parameter int unsigned TAG_W   = l1_pkg::L1_TAG_W,
    parameter int unsigned BEATS   = l1_pkg::L1_BEATS,
    parameter int unsigned DATA_W  = l1_pkg::L1_DATA_W
) ();
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned ADDR_W = TAG_W + IDX_W + BEAT_W + 2;

    logic               miss_val;
    logic               miss_ready;
    logic [IDX_W-1:0]   miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic [WAY_NUM-1:0] miss_way_vect;
    logic               miss_evict;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic               mem_req_val;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [DATA_W-1:0]  mem_req_wdata;
    logic               mem_rsp_val;
    logic [DATA_W-1:0]  mem_rsp_data;
    logic               arr_en;
    logic               arr_we;
    logic [WAY_NUM-1:0] arr_way_vect;
    logic [IDX_W-1:0]   arr_idx;
    logic [BEAT_W-1:0]  arr_beat;
    logic [DATA_W-1:0]  arr_wdata;
    logic [DATA_W-1:0]  arr_rdata;
    logic               tag_we;
    logic [TAG_W-1:0]   tag_wdata;
    logic               refill_done;

    // Controller side
    modport master (
        input  miss_val, miss_idx, miss_tag, miss_way_vect, miss_evict, victim_dirty,
               victim_tag, mem_req_ready, mem_rsp_val, mem_rsp_data, arr_rdata,
        output miss_ready, mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, arr_en,
               arr_we, arr_way_vect, arr_idx, arr_beat, arr_wdata, tag_we, tag_wdata,
               refill_done
    );

    // Pipeline / memory / array side
    modport slave (
        output miss_val, miss_idx, miss_tag, miss_way_vect, miss_evict, victim_dirty,
               victim_tag, mem_req_ready, mem_rsp_val, mem_rsp_data, arr_rdata,
        input  miss_ready, mem_req_val, mem_req_we, mem_req_addr, mem_req_wdata, arr_en,
               arr_we, arr_way_vect, arr_idx, arr_beat, arr_wdata, tag_we, tag_wdata,
               refill_done
    );
endinterface

// File: rtl/l1_refill_ctrl.sv
// L1 miss handler: optional dirty write-back, line refill, tag update, completion pulse.
module l1_refill_ctrl
    import l1_pkg::*;
#(
    parameter int unsigned WAY_NUM = L1_WAY_NUM,
    parameter int unsigned IDX_W   = CORE_IDX_WIDTH,
    parameter int unsigned TAG_W   = L1_TAG_W,
    parameter int unsigned BEATS   = L1_BEATS,
    parameter int unsigned DATA_W  = L1_DATA_W
) (
    input logic              clk,
    input logic              rst,
    l1_refill_ctrl_if.master bus
);
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned ADDR_W = TAG_W + IDX_W + BEAT_W + 2;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [WAY_NUM-1:0] way_q, way_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    // Set for the first WB_REQ cycle, when arr_rdata still carries the beat just read.
    logic               rd_pend_q, rd_pend_d;

    logic accept, req_hs, last_beat, rsp_wr, arr_rd;
    logic [DATA_W-1:0] wb_data;

    assign accept    = bus.miss_val && (state_q == StIdle);
    assign req_hs    = ((state_q == StWbReq) || (state_q == StRfReq)) && bus.mem_req_ready;
    assign last_beat = (cnt_q == BEAT_W'(BEATS - 1));
    assign rsp_wr    = (state_q == StRfWait) && bus.mem_rsp_val;
    assign arr_rd    = (state_q == StWbRd);
    assign wb_data   = rd_pend_q ? bus.arr_rdata : wdata_q;

    // Next-state, beat counter and miss latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        vtag_d    = vtag_q;
        way_d     = way_q;
        wdata_d   = wdata_q;
        rd_pend_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d   = bus.miss_idx;
                    tag_d   = bus.miss_tag;
                    vtag_d  = bus.victim_tag;
                    way_d   = bus.miss_way_vect;
                    cnt_d   = '0;
                    state_d = (bus.miss_evict && bus.victim_dirty) ? StWbRd : StRfReq;
                end
            end
            StWbRd: begin
                rd_pend_d = 1'b1;
                state_d   = StWbReq;
            end
            StWbReq: begin
                if (rd_pend_q) begin
                    wdata_d = bus.arr_rdata;
                end
                if (req_hs) begin
                    cnt_d   = cnt_q + BEAT_W'(1);
                    state_d = last_beat ? StRfReq : StWbRd;
                end else begin
                    rd_pend_d = 1'b0;
                end
            end
            StRfReq: begin
                if (req_hs) begin
                    state_d = StRfWait;
                end
            end
            StRfWait: begin
                if (bus.mem_rsp_val) begin
                    cnt_d = cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d = StUpd;
                    end
                end
            end
            StUpd:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            tag_q     <= '0;
            vtag_q    <= '0;
            way_q     <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            vtag_q    <= vtag_d;
            way_q     <= way_d;
            wdata_q   <= wdata_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Outputs decode from registered state; only the refill write follows mem_rsp_val.
    always_comb begin
        bus.miss_ready    = (state_q == StIdle);
        bus.mem_req_val   = (state_q == StWbReq) || (state_q == StRfReq);
        bus.mem_req_we    = (state_q == StWbReq);
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        if (state_q == StWbReq) begin
            bus.mem_req_addr  = ADDR_W'(line_addr(64'(vtag_q), 64'(idx_q), 64'(cnt_q),
                                                  IDX_W, BEAT_W));
            bus.mem_req_wdata = wb_data;
        end else if (state_q == StRfReq) begin
            bus.mem_req_addr  = ADDR_W'(line_addr(64'(tag_q), 64'(idx_q), 64'd0,
                                                  IDX_W, BEAT_W));
        end
        bus.arr_en       = arr_rd || rsp_wr;
        bus.arr_we       = rsp_wr;
        bus.arr_way_vect = bus.arr_en ? way_q : '0;
        bus.arr_idx      = bus.arr_en ? idx_q : '0;
        bus.arr_beat     = bus.arr_en ? cnt_q : '0;
        bus.arr_wdata    = rsp_wr ? bus.mem_rsp_data : '0;
        bus.tag_we       = (state_q == StUpd);
        bus.tag_wdata    = (state_q == StUpd) ? tag_q : '0;
        bus.refill_done  = (state_q == StDone);
    end

    // Protocol checks on the environment and on the request channel.
    a_rsp_in_wait: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rsp_val |-> (state_q == StRfWait));
    a_way_onehot: assert property (@(posedge clk) disable iff (rst)
        accept |-> $onehot(bus.miss_way_vect));
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.mem_req_val && !bus.mem_req_ready) |=>
        (bus.mem_req_val && $stable(bus.mem_req_addr) && $stable(bus.mem_req_wdata)));

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed and random bench for l1_refill_ctrl against a line-level reference model.
module tb_l1_refill_ctrl;
    import l1_pkg::*;

    localparam int unsigned WAYS  = L1_WAY_NUM;
    localparam int unsigned IDXW  = CORE_IDX_WIDTH;
    localparam int unsigned TAGW  = L1_TAG_W;
    localparam int unsigned BEATS = L1_BEATS;
    localparam int unsigned DW    = L1_DATA_W;
    localparam int unsigned BW    = L1_BEAT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_refill_ctrl_if bus ();

    l1_refill_ctrl #(
        .WAY_NUM(WAYS), .IDX_W(IDXW), .TAG_W(TAGW), .BEATS(BEATS), .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference data-array contents, written only by the stimulus block.
    logic [DW-1:0] arr_m [WAYS][64][BEATS];
    int errors = 0;
    int checks = 0;

    function automatic int way_of(input logic [WAYS-1:0] v);
        for (int i = 0; i < int'(WAYS); i++) if (v[i]) return i;
        return 0;
    endfunction

    // Synchronous data array: read data appears the cycle after the request.
    always @(posedge clk) begin
        if (bus.arr_en && !bus.arr_we)
            bus.arr_rdata <= arr_m[way_of(bus.arr_way_vect)][bus.arr_idx][bus.arr_beat];
    end

    function automatic logic [63:0] addr_of(input longint tag, input longint idx,
                                            input longint beat);
        return 64'(tag * (64'd1 << (IDXW + BW + 2)) + idx * (64'd1 << (BW + 2)) + beat * 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic scramble();
        bus.miss_idx      = IDXW'($urandom);
        bus.miss_tag      = TAGW'($urandom);
        bus.miss_way_vect = WAYS'($urandom);
        bus.miss_evict    = 1'($urandom);
        bus.victim_dirty  = 1'($urandom);
        bus.victim_tag    = TAGW'($urandom);
    endtask

    task automatic run_miss(input string nm, input int idx, input int tag, input int way,
                            input bit evict, input bit dirty, input int vtag, input int bp,
                            input int gap, input bit holes, input bit poke, input bit fixed);
        bit wb = evict && dirty;
        int nwb = wb ? int'(BEATS) : 0;
        logic [DW-1:0] rf [BEATS];
        logic [DW-1:0] wbd [BEATS];
        logic [63:0] o_addr[$], o_data[$];
        logic o_we[$];
        int w_way[$], w_idx[$], w_beat[$];
        logic [DW-1:0] w_data[$];
        int done_cyc = -1, last_wr = -1, wait_cnt = 0, gap_cnt = 0, sent = 0, tag_cnt = 0;
        int bp_cur = (bp >= 0) ? bp : int'($urandom_range(0, 3));
        bit rd_seen = 0, poked = 0, hold = 0;
        logic [63:0] p_addr = '0, p_data = '0, tag_val = '0;
        for (int b = 0; b < int'(BEATS); b++) begin
            rf[b]  = fixed ? DW'(32'h11 * (b + 1)) : DW'($urandom);
            wbd[b] = arr_m[way][idx][b];
        end
        @(negedge clk);
        chk({nm, "_accept_ready"}, 64'(bus.miss_ready), 64'd1);
        bus.miss_val      = 1'b1;
        bus.miss_idx      = IDXW'(idx);
        bus.miss_tag      = TAGW'(tag);
        bus.miss_way_vect = WAYS'(1 << way);
        bus.miss_evict    = evict;
        bus.victim_dirty  = dirty;
        bus.victim_tag    = TAGW'(vtag);
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.miss_val = 1'b0;
            scramble();
            if (poke && rd_seen && !poked) begin
                bus.miss_val      = 1'b1;
                bus.miss_way_vect = WAYS'(1);
            end
            bus.mem_rsp_val = 1'b0;
            if (rd_seen && sent < int'(BEATS)) begin
                if (gap_cnt >= gap && (!holes || $urandom_range(0, 2) != 0)) begin
                    bus.mem_rsp_val  = 1'b1;
                    bus.mem_rsp_data = rf[sent];
                    sent++;
                end else begin
                    gap_cnt++;
                end
            end
            bus.mem_req_ready = bus.mem_req_val && (wait_cnt >= bp_cur);
            #1;
            if (bus.miss_val) begin
                chk({nm, "_busy_ready"}, 64'(bus.miss_ready), 64'd0);
                poked = 1;
            end
            if (hold) begin
                chk({nm, "_hold_val"}, 64'(bus.mem_req_val), 64'd1);
                chk({nm, "_hold_addr"}, 64'(bus.mem_req_addr), p_addr);
                chk({nm, "_hold_wdata"}, 64'(bus.mem_req_wdata), p_data);
            end
            hold = 0;
            if (bus.mem_req_val) begin
                if (bus.mem_req_ready) begin
                    o_we.push_back(bus.mem_req_we);
                    o_addr.push_back(64'(bus.mem_req_addr));
                    o_data.push_back(64'(bus.mem_req_wdata));
                    if (!bus.mem_req_we) rd_seen = 1;
                    wait_cnt = 0;
                    bp_cur = (bp >= 0) ? bp : int'($urandom_range(0, 3));
                end else begin
                    wait_cnt++;
                    hold   = 1;
                    p_addr = 64'(bus.mem_req_addr);
                    p_data = 64'(bus.mem_req_wdata);
                end
            end
            if (bus.arr_en && bus.arr_we) begin
                w_way.push_back(int'(bus.arr_way_vect));
                w_idx.push_back(int'(bus.arr_idx));
                w_beat.push_back(int'(bus.arr_beat));
                w_data.push_back(bus.arr_wdata);
                last_wr = cyc;
            end
            if (bus.tag_we) begin
                tag_cnt++;
                tag_val = 64'(bus.tag_wdata);
            end
            if (bus.refill_done) done_cyc = cyc;
        end
        bus.mem_rsp_val   = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.miss_val      = 1'b0;
        chk({nm, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({nm, "_req_count"}, 64'(o_addr.size()), 64'(nwb + 1));
        for (int i = 0; i < nwb && i < o_addr.size(); i++) begin
            chk({nm, "_wb_we"}, 64'(o_we[i]), 64'd1);
            chk({nm, "_wb_addr"}, o_addr[i], addr_of(vtag, idx, i));
            chk({nm, "_wb_data"}, o_data[i], 64'(wbd[i]));
        end
        if (o_addr.size() == nwb + 1) begin
            chk({nm, "_rd_we"}, 64'(o_we[nwb]), 64'd0);
            chk({nm, "_rd_addr"}, o_addr[nwb], addr_of(tag, idx, 0));
        end
        chk({nm, "_wr_count"}, 64'(w_data.size()), 64'(BEATS));
        for (int b = 0; b < int'(BEATS) && b < w_data.size(); b++) begin
            chk({nm, "_wr_way"}, 64'(w_way[b]), 64'(1 << way));
            chk({nm, "_wr_idx"}, 64'(w_idx[b]), 64'(idx));
            chk({nm, "_wr_beat"}, 64'(w_beat[b]), 64'(b));
            chk({nm, "_wr_data"}, 64'(w_data[b]), 64'(rf[b]));
        end
        chk({nm, "_tag_cnt"}, 64'(tag_cnt), 64'd1);
        chk({nm, "_tag_val"}, tag_val, 64'(tag));
        chk({nm, "_done_lat"}, 64'(done_cyc - last_wr), 64'd2);
        if (poke) chk({nm, "_poked"}, 64'(poked), 64'd1);
        @(negedge clk);
        #1;
        chk({nm, "_done_pulse"}, 64'(bus.refill_done), 64'd0);
        chk({nm, "_idle_ready"}, 64'(bus.miss_ready), 64'd1);
        for (int b = 0; b < int'(BEATS); b++) arr_m[way][idx][b] = rf[b];
    endtask

    initial begin
        int tag_seen, nhs, reached;
        for (int w = 0; w < int'(WAYS); w++)
            for (int s = 0; s < 64; s++)
                for (int b = 0; b < int'(BEATS); b++) arr_m[w][s][b] = DW'($urandom);
        rst = 1'b1;
        bus.miss_val = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_val = 1'b0;
        bus.mem_rsp_data = '0;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("rst_req_val", 64'(bus.mem_req_val), 64'd0);
        chk("rst_req_we", 64'(bus.mem_req_we), 64'd0);
        chk("rst_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("rst_req_wdata", 64'(bus.mem_req_wdata), 64'd0);
        chk("rst_arr_en", 64'(bus.arr_en), 64'd0);
        chk("rst_arr_we", 64'(bus.arr_we), 64'd0);
        chk("rst_arr_way", 64'(bus.arr_way_vect), 64'd0);
        chk("rst_tag_we", 64'(bus.tag_we), 64'd0);
        chk("rst_done", 64'(bus.refill_done), 64'd0);

        run_miss("clean", 5, 'h1A2B, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int b = 0; b < int'(BEATS); b++) arr_m[1][9][b] = DW'(32'hA0 + b);
        run_miss("dirty", 9, 'h2F00F, 1, 1, 1, 'h3, 0, 0, 0, 0, 0);
        run_miss("bpress", 9, 'h155, 1, 1, 1, 'h2F00F, 5, 2, 0, 0, 0);
        run_miss("busy", 12, 'h3ABCD, 0, 0, 0, 0, 1, 3, 0, 1, 0);
        run_miss("evclean", 12, 'h777, 0, 1, 0, 'h3ABCD, 0, 0, 0, 0, 0);

        // Reset while the second write-back beat is waiting for the memory.
        @(negedge clk);
        bus.miss_val = 1'b1;
        bus.miss_idx = IDXW'(7);
        bus.miss_tag = TAGW'('h123);
        bus.miss_way_vect = WAYS'(8);
        bus.miss_evict = 1'b1;
        bus.victim_dirty = 1'b1;
        bus.victim_tag = TAGW'('h2A);
        tag_seen = 0;
        nhs = 0;
        reached = 0;
        for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
            @(negedge clk);
            bus.miss_val = 1'b0;
            bus.mem_req_ready = bus.mem_req_val && bus.mem_req_we && (nhs == 0);
            #1;
            if (bus.tag_we) tag_seen++;
            if (bus.mem_req_val && bus.mem_req_ready) nhs++;
            else if (nhs == 1 && bus.mem_req_val && bus.mem_req_we) reached = 1;
        end
        chk("mid_reached", 64'(reached), 64'd1);
        rst = 1'b1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("mid_req_val", 64'(bus.mem_req_val), 64'd0);
        chk("mid_req_addr", 64'(bus.mem_req_addr), 64'd0);
        chk("mid_req_wdata", 64'(bus.mem_req_wdata), 64'd0);
        chk("mid_arr_en", 64'(bus.arr_en), 64'd0);
        chk("mid_tag_we", 64'(bus.tag_we + tag_seen), 64'd0);
        chk("mid_done", 64'(bus.refill_done), 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) begin
            run_miss("rand", int'($urandom_range(0, 3)), int'(TAGW'($urandom)),
                     int'($urandom_range(0, WAYS - 1)), 1'($urandom), 1'($urandom),
                     int'(TAGW'($urandom)), -1, int'($urandom_range(0, 3)), 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
